// File: rtl/memory_responder_pkg.sv
// Shared processor constants: word width, FSM state encoding and latched request payload.
package memory_responder_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic              is_write;
    logic [WORD_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/memory_responder_if.sv
// Control <-> memory responder request/response bus.
interface memory_responder_if;
  import memory_responder_pkg::*;

  logic              MemR;
  logic              MemW;
  logic [ADDR_W-1:0] Addr;
  logic [WORD_W-1:0] WData;
  logic [WORD_W-1:0] RData;
  logic              Ready;
  logic              Busy;
  logic              Err;
  logic [1:0]        current_state;

  modport master (
    output MemR, MemW, Addr, WData,
    input  RData, Ready, Busy, Err, current_state
  );

  modport slave (
    input  MemR, MemW, Addr, WData,
    output RData, Ready, Busy, Err, current_state
  );

endinterface

// File: rtl/memory_responder_mem_array.sv
// Word-addressed storage: synchronous write, registered read port.
module mem_array
  import memory_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WORD_W-1:0]    wdata,
  output logic [WORD_W-1:0]    rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [WORD_W-1:0] mem [DEPTH];

  // Array contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/memory_responder.sv
// Fixed-latency memory responder: captures one request in IDLE, waits LATENCY
// cycles, performs the access on entry to DONE and pulses Ready for one cycle.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned ADDR_BITS = 8
) (
  input logic              CLK,
  input logic              Reset,
  memory_responder_if.slave bus
);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  req_t                   req_q, req_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   ready_q, busy_q, err_q, err_d;
  logic                   req_c, bad_c;
  logic                   mem_we_c, mem_re_c;
  logic [ADDR_BITS-1:0]   acc_addr_c;
  logic [WORD_W-1:0]      acc_wdata_c;
  logic [WORD_W-1:0]      rdata;

  // Next-state, capture and access-strobe logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    addr_d      = addr_q;
    err_d       = 1'b0;
    mem_we_c    = 1'b0;
    mem_re_c    = 1'b0;
    acc_addr_c  = addr_q;
    acc_wdata_c = req_q.wdata;

    req_c = bus.MemR | bus.MemW;
    bad_c = (bus.MemR & bus.MemW) | ((bus.Addr >> ADDR_BITS) != '0);

    case (state_q)
      ST_IDLE: begin
        // Zero-latency accesses use the live bus since capture happens on the same edge.
        acc_addr_c  = bus.Addr[ADDR_BITS-1:0];
        acc_wdata_c = bus.WData;
        if (req_c) begin
          req_d  = '{is_write: bus.MemW, wdata: bus.WData};
          addr_d = bus.Addr[ADDR_BITS-1:0];
          if (bad_c) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else if (LATENCY == 0) begin
            state_d  = ST_DONE;
            mem_we_c = bus.MemW;
            mem_re_c = bus.MemR;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(LATENCY);
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = ST_DONE;
          mem_we_c = req_q.is_write;
          mem_re_c = !req_q.is_write;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      addr_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      ready_q <= (state_d == ST_DONE);
      busy_q  <= (state_d != ST_IDLE);
      err_q   <= err_d;
    end
  end

  // A reset on the commit edge must not let the write through.
  mem_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_mem_array (
    .clk  (CLK),
    .rst_n(Reset),
    .we   (mem_we_c & Reset),
    .re   (mem_re_c),
    .addr (acc_addr_c),
    .wdata(acc_wdata_c),
    .rdata(rdata)
  );

  assign bus.RData         = rdata;
  assign bus.Ready         = ready_q;
  assign bus.Busy          = busy_q;
  assign bus.Err           = err_q;
  assign bus.current_state = state_q;

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, number of wait cycles between request capture and response (legal 0..7).
REQ-002 SHALL have parameter ADDR_BITS, default 8, log2 of word depth of the internal 16-bit memory array.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port MemR  input  1  read request from Control; held high until Ready.
REQ-006 SHALL have port MemW  input  1  write request from Control; held high until Ready.
REQ-007 SHALL have port Addr  input  16  word address.
REQ-008 SHALL have port WData  input  16  write data.
REQ-009 SHALL have port RData  output  16  registered read data, valid while Ready=1 after a read.
REQ-010 SHALL have port Ready  output  1  one-cycle response pulse; the request is complete.
REQ-011 SHALL have port Busy  output  1  high while a request is in progress (WAIT or DONE).
REQ-012 SHALL have port Err  output  1  high with Ready when a request was rejected.
REQ-013 SHALL have port current_state  output  2  FSM state: IDLE=0, WAIT=1, DONE=2.

Function
REQ-014 SHALL sample requests only in IDLE; a request is MemR=1 or MemW=1 at a rising edge.
REQ-015 SHALL, on a valid request, latch Addr, WData and the direction, and load the wait counter with LATENCY.
REQ-016 SHALL go from IDLE to WAIT when LATENCY>0, and directly to DONE when LATENCY=0.
REQ-017 SHALL decrement the counter once per cycle in WAIT and move to DONE on the edge where the counter equals 1.
REQ-018 SHALL perform the access on the edge entering DONE: a write stores the latched WData into mem[latched Addr]; a read loads RData from mem[latched Addr].
REQ-019 SHALL hold Ready=1 for exactly the one cycle spent in DONE, then return to IDLE.
REQ-020 SHALL give fixed latency: a request sampled at edge k produces Ready high during cycle k+LATENCY+1.
REQ-021 SHALL ignore MemR/MemW/Addr/WData while Busy=1; a request still held in the cycle after DONE is sampled as a new request.
REQ-022 SHALL reject a request with MemR=1 and MemW=1 together: no memory access, go to DONE directly, and drive Err=1 with Ready=1.
REQ-023 SHALL reject a request with any Addr bit at or above ADDR_BITS set: no memory access, go to DONE directly, and drive Err=1 with Ready=1.
REQ-024 SHALL hold RData at its last read value except on a successful read; rejected requests and writes SHALL NOT change it.
REQ-025 SHALL keep a read to the address written by the immediately preceding request coherent (returns the new data).

Reset
REQ-026 SHALL, with Reset=0 at a rising edge, force state to IDLE, counter to 0, and RData, Ready, Busy and Err to 0.
REQ-027 SHALL, on reset during WAIT or DONE, abort the request with no Ready pulse; a write still in WAIT SHALL NOT be committed.
REQ-028 SHALL NOT reset the memory array contents.

Structure
REQ-029 SHALL take the state encodings (IDLE, WAIT, DONE) and the 16-bit word width from the shared processor constants package used by Control.
REQ-030 SHALL place the memory array in one sub-module, mem_array (synchronous write, registered read), with the FSM and counter in memory_responder.

Verification
REQ-031 Reset=0 for 2 cycles, then release -> current_state=0, Ready=0, Busy=0, RData=0000.
REQ-032 LATENCY=2: write Addr=0010, WData=BEEF, then read Addr=0010 -> each Ready pulse occurs 3 cycles after sampling; the read returns RData=BEEF, Err=0.
REQ-033 LATENCY=0: read Addr=0005 after writing 1234 -> Ready in the cycle right after sampling, RData=1234.
REQ-034 MemR=MemW=1, or Addr=0100 with ADDR_BITS=8 -> Ready=1, Err=1 one cycle later; memory and RData unchanged.
REQ-035 Write 00AA to Addr=0003, and assert Reset=0 while in WAIT -> no Ready; a later read of 0003 returns the old value.
REQ-036 Toggle Addr/WData while Busy=1 -> the response reflects only the latched request.
